// File: rtl/aes_cipher_iter.sv
// rtl/aes_cipher_iter.sv - iterative AES encryption core, one round per clock
// Optional AES_CIPHER_KEY_LATCH_EN captures the expanded key on accept.
module aes_cipher_iter #(
  parameter int KEY_W  = 1920,
  parameter int DATA_W = 128
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [KEY_W-1:0]  i_expanded_key,
  input  logic [3:0]        i_nr,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  // Round key r sits at the top of the key after shifting left by r blocks.
  function automatic logic [127:0] rk_sel(input logic [KEY_W-1:0] k, input logic [3:0] r);
    logic [KEY_W-1:0] sh;
    sh = k << {r, 7'b0};
    return sh[KEY_W-1 -: 128];
  endfunction

  state_t            state_q, state_d;
  logic [127:0]      st_q, st_d;
  logic [127:0]      out_q, out_d;
  logic [3:0]        rnd_q, rnd_d;
  logic [3:0]        nr_q, nr_d;
  logic [KEY_W-1:0]  key_src;
  logic [127:0]      sb, sr, mc, rk;
  logic              nr_ok;

`ifdef AES_CIPHER_KEY_LATCH_EN
  logic [KEY_W-1:0]  key_q, key_d;
  assign key_src = key_q;
`else
  assign key_src = i_expanded_key;
`endif

  assign nr_ok   = (i_nr == 4'd10) || (i_nr == 4'd12) || (i_nr == 4'd14);
  assign rk      = rk_sel(key_src, rnd_q);
  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign o_data  = out_q;

  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int i = 0; i < 16; i++)
      sb[127-8*i -: 8] = SBOX[2047 - 8*st_q[127-8*i -: 8] -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
    for (int c = 0; c < 4; c++)
      mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    out_d   = out_q;
    rnd_d   = rnd_q;
    nr_d    = nr_q;
`ifdef AES_CIPHER_KEY_LATCH_EN
    key_d   = key_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_valid && nr_ok) begin
          st_d    = i_data ^ rk_sel(i_expanded_key, 4'd0);
          rnd_d   = 4'd1;
          nr_d    = i_nr;
          state_d = S_ROUND;
`ifdef AES_CIPHER_KEY_LATCH_EN
          key_d   = i_expanded_key;
`endif
        end
      end
      S_ROUND: begin
        if (rnd_q == nr_q) begin
          st_d    = sr ^ rk;
          out_d   = sr ^ rk;
          state_d = S_DONE;
        end else begin
          st_d    = mc ^ rk;
          rnd_d   = rnd_q + 4'd1;
        end
      end
      S_DONE: begin
        if (i_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      out_q   <= '0;
      rnd_q   <= '0;
      nr_q    <= '0;
`ifdef AES_CIPHER_KEY_LATCH_EN
      key_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      out_q   <= out_d;
      rnd_q   <= rnd_d;
      nr_q    <= nr_d;
`ifdef AES_CIPHER_KEY_LATCH_EN
      key_q   <= key_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb/tb_aes_cipher_iter.sv - directed known-answer bench for aes_cipher_iter
module tb_aes_cipher_iter;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [127:0]  i_data;
  logic [1919:0] i_expanded_key;
  logic [3:0]    i_nr;
  logic          o_valid;
  logic          i_ready;
  logic [127:0]  o_data;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] sbm [256];

  typedef struct {
    int            nr;
    logic [1919:0] key;
    logic [127:0]  exp;
  } vec_t;

  vec_t vecs [3];

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  aes_cipher_iter dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_data         (i_data),
    .i_expanded_key (i_expanded_key),
    .i_nr           (i_nr),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_data         (o_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from the field inverse plus the affine map, independent of any table.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
          {inv[3:0], inv[7:4]} ^ 8'h63;
      sbm[x] = s;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbm[w[31:24]], sbm[w[23:16]], sbm[w[15:8]], sbm[w[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [1919:0] k  = '0;
    int total = 4 * (nk + 7);
    for (int j = 0; j < 60; j++) w[j] = '0;
    for (int j = 0; j < nk; j++)
      w[j] = {8'(4*j), 8'(4*j+1), 8'(4*j+2), 8'(4*j+3)};
    for (int i = nk; i < total; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 60; i++) k[1919-32*i -: 32] = w[i];
    return k;
  endfunction

  task automatic run_block(input vec_t v, input int bp, input bit corrupt);
    int cyc = 0;
    bit busy_ok = 1'b1;
    i_ready        = (bp == 0);
    i_data         = PT;
    i_expanded_key = v.key;
    i_nr           = 4'(v.nr);
    i_valid        = 1'b1;
    check("ready_before_accept", 128'(o_ready), 128'd1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    if (corrupt) i_expanded_key = ~v.key;
    while (!o_valid && cyc < 40) begin
      if (o_ready) busy_ok = 1'b0;
      @(posedge i_clk); #1;
      cyc++;
    end
    check("latency_edges", 128'(cyc), 128'(v.nr));
    check("ready_low_while_busy", 128'(busy_ok), 128'd1);
    check("ciphertext", o_data, v.exp);
    check("ready_low_in_done", 128'(o_ready), 128'd0);
    for (int k = 0; k < bp; k++) begin
      @(posedge i_clk); #1;
      check("bp_valid_held", 128'(o_valid), 128'd1);
      check("bp_data_held", o_data, v.exp);
      check("bp_ready_low", 128'(o_ready), 128'd0);
    end
    i_ready = 1'b1;
    check("ready_low_handshake_cycle", 128'(o_ready), 128'd0);
    @(posedge i_clk); #1;
    check("valid_drops_after_handshake", 128'(o_valid), 128'd0);
    check("ready_rises_after_handshake", 128'(o_ready), 128'd1);
    i_expanded_key = v.key;
  endtask

  initial begin
    bit ok;
    bit pr;
    int acc;

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_data  = '0;
    i_nr    = '0;
    i_expanded_key = '0;

    build_sbox();
    vecs[0] = '{10, expand(4), 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{12, expand(6), 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
    vecs[2] = '{14, expand(8), 128'h8ea2b7ca516745bfeafc49904b496089};

    repeat (2) @(posedge i_clk);
    #1;
    check("reset_ready", 128'(o_ready), 128'd1);
    check("reset_valid", 128'(o_valid), 128'd0);
    check("reset_data", o_data, 128'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    for (int v = 0; v < 3; v++) run_block(vecs[v], 0, 1'b0);

    run_block(vecs[0], 5, 1'b0);

    // Unsupported round count must never be taken.
    ok = 1'b1;
    i_nr = 4'd11;
    i_data = PT;
    i_expanded_key = vecs[0].key;
    i_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge i_clk); #1;
      if (!o_ready || o_valid) ok = 1'b0;
    end
    i_valid = 1'b0;
    check("bad_nr_ignored", 128'(ok), 128'd1);

    // Valid held across the whole busy period gives a single accept.
    acc = 0;
    i_ready = 1'b0;
    i_nr = 4'd10;
    i_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      pr = o_ready;
      @(posedge i_clk); #1;
      if (pr && !o_ready) acc++;
    end
    check("held_valid_done", 128'(o_valid), 128'd1);
    check("held_valid_data", o_data, vecs[0].exp);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    check("held_valid_one_accept", 128'(acc), 128'd1);

    // Reset in the middle of a block.
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    check("pre_reset_busy", 128'(o_ready), 128'd0);
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    check("abort_valid", 128'(o_valid), 128'd0);
    check("abort_data", o_data, 128'd0);
    check("abort_ready", 128'(o_ready), 128'd1);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    run_block(vecs[0], 0, 1'b0);

`ifdef AES_CIPHER_KEY_LATCH_EN
    run_block(vecs[2], 0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
